// File: rtl/fft_frame_loader.sv
// Ping-pong frame buffer feeding the 64-point FFT core: stores serial samples,
// then issues ST followed by N/2 even/odd pairs. Optional macro: HANN_WINDOW_EN.
module fft_frame_loader #(
  parameter int N   = 64,
  parameter int DW  = 16,
  parameter int GAP = 224
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic signed [DW-1:0] S_DATA,
  input  logic                 S_VALID,
  output logic                 S_READY,
  output logic                 ST,
  output logic signed [DW-1:0] I1,
  output logic signed [DW-1:0] I2,
  output logic                 BUSY,
  output logic [7:0]           FRAMES
);

  localparam int AW = $clog2(N);
  localparam int KW = AW - 1;
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BURST, S_GAP} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             full_q, full_d;
  logic                   fb_q, fb_d;
  logic                   nb_q, nb_d;
  logic [AW-1:0]          wptr_q, wptr_d;
  logic [KW-1:0]          k_q, k_d;
  logic [GW-1:0]          gcnt_q, gcnt_d;
  logic                   st_q, st_d;
  logic                   busy_q, busy_d;
  logic signed [DW-1:0]   i1_q, i1_d, i2_q, i2_d;
  logic [7:0]             frames_q, frames_d;
  logic signed [DW-1:0]   mem_q [2][N];
  logic                   accept;
  logic signed [DW-1:0]   wr_data;

`ifdef HANN_WINDOW_EN
  // w[n] = round(128*(1-cos(2*pi*n/64))), symmetric about n=32
  function automatic logic [8:0] hann_w(input logic [5:0] n);
    logic [5:0] m;
    m = n[5] ? 6'(7'd64 - {1'b0, n}) : n;
    case (m)
      6'd0:  return 9'd0;   6'd1:  return 9'd1;   6'd2:  return 9'd2;
      6'd3:  return 9'd6;   6'd4:  return 9'd10;  6'd5:  return 9'd15;
      6'd6:  return 9'd22;  6'd7:  return 9'd29;  6'd8:  return 9'd37;
      6'd9:  return 9'd47;  6'd10: return 9'd57;  6'd11: return 9'd68;
      6'd12: return 9'd79;  6'd13: return 9'd91;  6'd14: return 9'd103;
      6'd15: return 9'd115; 6'd16: return 9'd128; 6'd17: return 9'd141;
      6'd18: return 9'd153; 6'd19: return 9'd165; 6'd20: return 9'd177;
      6'd21: return 9'd188; 6'd22: return 9'd199; 6'd23: return 9'd209;
      6'd24: return 9'd219; 6'd25: return 9'd227; 6'd26: return 9'd234;
      6'd27: return 9'd241; 6'd28: return 9'd246; 6'd29: return 9'd250;
      6'd30: return 9'd254; 6'd31: return 9'd255; 6'd32: return 9'd256;
      default: return 9'd0;
    endcase
  endfunction

  // Arithmetic shift by 8 truncates toward -inf
  function automatic logic signed [DW-1:0] apply_window(input logic signed [DW-1:0] x,
                                                        input logic [5:0] n);
    logic signed [DW+9:0] prod;
    prod = x * $signed({1'b0, hann_w(n)});
    return prod[DW+7:8];
  endfunction

  assign wr_data = apply_window(S_DATA, 6'(wptr_q));
`else
  assign wr_data = S_DATA;
`endif

  assign S_READY = !full_q[fb_q];
  assign accept  = S_VALID && S_READY;

  always_comb begin
    state_d  = state_q;
    full_d   = full_q;
    nb_d     = nb_q;
    k_d      = k_q;
    frames_d = frames_q;
    wptr_d   = accept ? wptr_q + AW'(1) : wptr_q;
    gcnt_d   = (gcnt_q != '0) ? gcnt_q - GW'(1) : gcnt_q;

    if (accept && wptr_q == AW'(N - 1))
      full_d[fb_q] = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (full_q[nb_q] && gcnt_q == '0) begin
          state_d  = S_START;
          gcnt_d   = GW'(GAP - 1);
          frames_d = frames_q + 8'd1;
        end
      end
      S_START: begin
        state_d = S_BURST;
        k_d     = '0;
      end
      S_BURST: begin
        if (k_q == KW'(N / 2 - 1)) begin
          state_d      = S_GAP;
          full_d[nb_q] = 1'b0;
          nb_d         = ~nb_q;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      // Leave one cycle early so IDLE sees the counter expire exactly GAP after ST
      S_GAP: begin
        if (gcnt_q <= GW'(1))
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Move filling to the other bank as soon as it is free (covers stall release)
    fb_d = (full_d[fb_q] && !full_d[~fb_q]) ? ~fb_q : fb_q;

    st_d   = (state_d == S_START);
    busy_d = (state_d != S_IDLE);
    i1_d   = '0;
    i2_d   = '0;
    if (state_d == S_BURST) begin
      i1_d = mem_q[nb_q][{k_d, 1'b0}];
      i2_d = mem_q[nb_q][{k_d, 1'b1}];
    end
  end

  always_ff @(posedge CK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      full_q   <= '0;
      fb_q     <= 1'b0;
      nb_q     <= 1'b0;
      wptr_q   <= '0;
      k_q      <= '0;
      gcnt_q   <= '0;
      st_q     <= 1'b0;
      busy_q   <= 1'b0;
      i1_q     <= '0;
      i2_q     <= '0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      full_q   <= full_d;
      fb_q     <= fb_d;
      nb_q     <= nb_d;
      wptr_q   <= wptr_d;
      k_q      <= k_d;
      gcnt_q   <= gcnt_d;
      st_q     <= st_d;
      busy_q   <= busy_d;
      i1_q     <= i1_d;
      i2_q     <= i2_d;
      frames_q <= frames_d;
    end
  end

  always_ff @(posedge CK) begin
    if (accept)
      mem_q[fb_q][wptr_q] <= wr_data;
  end

  assign ST     = st_q;
  assign BUSY   = busy_q;
  assign I1     = i1_q;
  assign I2     = i2_q;
  assign FRAMES = frames_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Randomized scoreboard bench for fft_frame_loader: a frame-level model queues
// expected pairs per completed frame; a negedge monitor pops and compares.
module tb_fft_frame_loader;
  localparam int N   = 64;
  localparam int DW  = 16;
  localparam int GAP = 224;

  logic CK = 1'b0;
  logic RST;
  logic signed [DW-1:0] S_DATA, I1, I2;
  logic S_VALID, S_READY, ST, BUSY;
  logic [7:0] FRAMES;

  fft_frame_loader #(.N(N), .DW(DW), .GAP(GAP)) dut (
    .CK(CK), .RST(RST), .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY),
    .ST(ST), .I1(I1), .I2(I2), .BUSY(BUSY), .FRAMES(FRAMES)
  );

  always #5 CK = ~CK;

  typedef struct {logic signed [DW-1:0] a; logic signed [DW-1:0] b;} pair_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  pair_t expq[$];
  logic signed [DW-1:0] frame_buf[$];
  int st_log[$];
  int burst_left = 0;
  int last_st = 0;
  bit have_prev = 0;
  logic [7:0] frames_exp = 8'd0;
  bit prev_rdy = 1'b1;
  int rdy_fall = -1;
  int rdy_rise = -1;

  always @(posedge CK) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic signed [DW-1:0] win(input int n, input logic signed [DW-1:0] x);
`ifdef HANN_WINDOW_EN
    int w;
    int p;
    w = $rtoi(128.0 * (1.0 - $cos(2.0 * 3.14159265358979 * n / 64.0)) + 0.5);
    p = int'(x) * w;
    return DW'(p >>> 8);
`else
    return x;
`endif
  endfunction

  // Reference model: every N accepted samples form one frame of N/2 pairs
  function automatic void model_push(input logic signed [DW-1:0] x);
    pair_t pr;
    frame_buf.push_back(win(frame_buf.size(), x));
    if (frame_buf.size() == N) begin
      for (int k = 0; k < N / 2; k++) begin
        pr.a = frame_buf[2 * k];
        pr.b = frame_buf[2 * k + 1];
        expq.push_back(pr);
      end
      frame_buf.delete();
    end
  endfunction

  always @(negedge CK) begin
    pair_t e;
    if (!RST) begin
      burst_left = 0;
    end else if (ST) begin
      chk("st_i1_zero", I1, 0);
      chk("st_i2_zero", I2, 0);
      if (have_prev) chk("st_spacing_ok", (cyc - last_st) >= GAP, 1);
      st_log.push_back(cyc);
      last_st = cyc;
      have_prev = 1'b1;
      burst_left = N / 2;
      frames_exp = frames_exp + 8'd1;
    end else if (burst_left > 0) begin
      if (burst_left == N / 2) chk("frames", FRAMES, frames_exp);
      chk("burst_busy", BUSY, 1);
      if (expq.size() == 0) begin
        chk("pair_available", 0, 1);
      end else begin
        e = expq.pop_front();
        chk("i1_pair", I1, e.a);
        chk("i2_pair", I2, e.b);
      end
      burst_left--;
    end else begin
      chk("idle_i1_zero", I1, 0);
      chk("idle_i2_zero", I2, 0);
    end
  end

  always @(negedge CK) begin
    if (RST) begin
      if (prev_rdy && !S_READY) rdy_fall = cyc;
      if (!prev_rdy && S_READY) rdy_rise = cyc;
    end
    prev_rdy = S_READY;
  end

  task automatic send(input int n, input bit ramp, input bit toggle,
                      output int first, output int last);
    int cnt;
    int guard;
    bit v;
    bit rdy;
    bit ph;
    logic signed [DW-1:0] d;
    cnt = 0; guard = 0; ph = 1'b0; first = -1; last = -1;
    d = ramp ? DW'(0) : DW'($urandom);
    while (cnt < n && guard < 5000) begin
      @(negedge CK);
      v = toggle ? ~ph : 1'b1;
      ph = ~ph;
      S_VALID = v;
      S_DATA = d;
      rdy = S_READY;
      @(posedge CK);
      #1;
      if (v && rdy) begin
        model_push(d);
        if (first < 0) first = cyc;
        last = cyc;
        cnt++;
        d = ramp ? DW'(cnt) : DW'($urandom);
      end
      guard++;
    end
    @(negedge CK);
    S_VALID = 1'b0;
    if (cnt < n) chk("send_timeout", cnt, n);
  endtask

  task automatic wait_st(input int m);
    int g;
    g = 0;
    while (st_log.size() < m && g < 2000) begin
      @(negedge CK);
      g++;
    end
    if (st_log.size() < m) chk("st_timeout", st_log.size(), m);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((expq.size() != 0 || burst_left != 0 || BUSY) && g < 3000) begin
      @(negedge CK);
      g++;
    end
    chk("drained", expq.size() + burst_left, 0);
    repeat (GAP) @(negedge CK);
  endtask

  initial begin
    int f;
    int l;
    int n0;
    RST = 1'b0;
    S_VALID = 1'b0;
    S_DATA = '0;
    repeat (3) @(posedge CK);
    #1;
    chk("rst_st", ST, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_frames", FRAMES, 0);
    chk("rst_ready", S_READY, 1);
    chk("rst_i1", I1, 0);
    @(negedge CK);
    RST = 1'b1;

    // Ramp frame
    send(N, 1'b1, 1'b0, f, l);
    wait_st(1);
    chk("ramp_st_latency", st_log[0] - l, 1);
    wait_idle();
    chk("ramp_frames", FRAMES, 1);
    chk("ramp_i1_after", I1, 0);

    // Three back-to-back frames with a bank stall
    n0 = st_log.size();
    rdy_fall = -1;
    rdy_rise = -1;
    send(3 * N, 1'b0, 1'b0, f, l);
    wait_st(n0 + 3);
    chk("b2b_st0", st_log[n0] - f, N);
    chk("b2b_gap1", st_log[n0 + 1] - st_log[n0], GAP);
    chk("b2b_gap2", st_log[n0 + 2] - st_log[n0 + 1], GAP);
    chk("b2b_ready_fall", rdy_fall - f, 3 * N - 1);
    chk("b2b_ready_rise", rdy_rise - st_log[n0 + 1], N / 2 + 1);
    wait_idle();
    chk("b2b_frames", FRAMES, 4);

    // Valid toggling every cycle
    n0 = st_log.size();
    send(N, 1'b0, 1'b1, f, l);
    wait_st(n0 + 1);
    chk("toggle_accept_span", l - f, 2 * N - 2);
    chk("toggle_st_latency", st_log[n0] - l, 1);
    wait_idle();

    // Reset during the burst, at pair k=10
    n0 = st_log.size();
    send(N, 1'b0, 1'b0, f, l);
    wait_st(n0 + 1);
    while (cyc < st_log[n0] + 11) @(negedge CK);
    #2;
    RST = 1'b0;
    #1;
    chk("arst_st", ST, 0);
    chk("arst_i1", I1, 0);
    chk("arst_i2", I2, 0);
    chk("arst_busy", BUSY, 0);
    chk("arst_ready", S_READY, 1);
    chk("arst_frames", FRAMES, 0);
    expq.delete();
    frame_buf.delete();
    have_prev = 1'b0;
    frames_exp = 8'd0;
    repeat (2) @(negedge CK);
    RST = 1'b1;
    n0 = st_log.size();
    repeat (20) @(negedge CK);
    chk("arst_no_st", st_log.size(), n0);
    send(N, 1'b0, 1'b0, f, l);
    wait_st(n0 + 1);
    chk("arst_st_latency", st_log[n0] - l, 1);
    wait_idle();
    chk("arst_frames_after", FRAMES, 1);
    chk("final_queue_empty", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
